task_v: RTL and testbench
=========================

Name: task_v

Overview:
- Evaluates a fixed 4-input Boolean function f(a,b,c,d) and exposes both a combinational and a registered result.
- Tracks which of the 16 input combinations have been applied since reset or clear, so an exhaustive sweep can be confirmed in hardware.
- Sits as a leaf logic block; upstream drives a..d, downstream samples f or f_q.

Parameters:
- TRUTH_TABLE, 16'hF888, truth table indexed by idx = {a,b,c,d} (a = MSB). Default implements f = (a&b) | (c&d).
- CNT_W, 5, width of hit_cnt. Must be ≥5 to hold the value 16.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a  in  1  function input, idx bit 3.
- b  in  1  function input, idx bit 2.
- c  in  1  function input, idx bit 1.
- d  in  1  function input, idx bit 0.
- clr  in  1  synchronous clear of coverage state.
- f  out  1  combinational result, TRUTH_TABLE[idx].
- f_q  out  1  f registered one cycle.
- seen  out  16  bit i set once idx==i has been sampled.
- hit_cnt  out  CNT_W  popcount of seen (0..16).
- all_seen  out  1  high when seen == 16'hFFFF.

Behaviour:
- idx = {a,b,c,d}. Combinational f = TRUTH_TABLE[idx]; no clock involvement, zero latency.
- Default function:
  - f = 1 for idx 3, 7, 11, 12, 13, 14, 15.
  - f = 0 for idx 0, 1, 2, 4, 5, 6, 8, 9, 10.
- f_q <= f on every rising clk edge; latency exactly 1 cycle.
- seen:
  - Each rising edge with clr=0: seen <= seen | (16'b1 << idx).
  - Bits never clear except by reset or clr.
- clr=1 at an edge: seen <= 16'b0, so that cycle's idx is NOT recorded. f_q still updates normally.
- hit_cnt and all_seen:
  - Both are derived combinationally from registered seen.
  - hit_cnt reaches 16 only after all combinations are sampled.
  - all_seen = (hit_cnt == 16).
- Reset (rst_n=0, asynchronous assert):
  - f_q=0, seen=0, hit_cnt=0, all_seen=0 immediately.
  - Deassertion is synchronized by the integrating design.
  - f continues to follow inputs during reset.
- Reset mid-sweep: all coverage is lost; recording resumes at the first edge after release.
- Repeated idx values: no effect beyond the first occurrence; hit_cnt does not double-count.
- X/Z on inputs: out of scope; inputs must be driven to 0/1.

Optional Feature:
- Macro TASKV_PARITY_EN.
- When defined:
  - Adds output port par_q (1 bit), registered a^b^c^d.
  - par_q resets to 0 with rst_n and updates every edge with the same 1-cycle latency as f_q.
- When undefined:
  - The port and its register are absent.
  - All other behaviour is identical.

Test Plan:
- Reset then idx=0 (a=b=c=d=0) -> f=0; after 1 edge f_q=0, seen=16'h0001, hit_cnt=1.
- Sweep idx 0..15, one per 10 ns cycle -> f sequence 0,0,0,1,0,0,0,1,0,0,0,1,1,1,1,1; f_q lags by one cycle; after the final edge seen=16'hFFFF, hit_cnt=16, all_seen=1.
- Apply idx=15 for 5 consecutive cycles from reset -> seen=16'h8000, hit_cnt=1, f=1, f_q=1.
- After a full sweep, assert clr for one edge with idx=5 -> seen=0, hit_cnt=0, all_seen=0; next edge with idx=5 and clr=0 -> seen=16'h0020.
- Pull rst_n low asynchronously mid-sweep (between edges, after 8 combos) -> seen, f_q and hit_cnt go to 0 immediately, before the next clock edge.
- With TASKV_PARITY_EN defined, apply idx=7 (0111) -> par_q=1 after 1 edge; apply idx=12 (1100) -> par_q=0.

Source files
------------

// File: rtl/task_v.sv
// Fixed 4-input Boolean function with a registered copy and input-combination coverage tracking.
// Optional macro TASKV_PARITY_EN adds a registered parity output par_q.
module task_v #(
   parameter logic [15:0] TRUTH_TABLE = 16'hF888,
   parameter int          CNT_W       = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             d,
   input  logic             clr,
   output logic             f,
`ifdef TASKV_PARITY_EN
   output logic             par_q,
`endif
   output logic             f_q,
   output logic [15:0]      seen,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             all_seen
);

   logic [3:0] idx;

   assign idx = {a, b, c, d};
   assign f   = TRUTH_TABLE[idx];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         f_q <= 1'b0;
      end else begin
         f_q <= f;
      end
   end

   // clr wins over recording, so the idx present on a clearing edge is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seen <= 16'h0000;
      end else if (clr) begin
         seen <= 16'h0000;
      end else begin
         seen <= seen | (16'h0001 << idx);
      end
   end

`ifdef TASKV_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_q <= 1'b0;
      end else begin
         par_q <= a ^ b ^ c ^ d;
      end
   end
`endif

   always_comb begin
      hit_cnt = '0;
      for (int i = 0; i < 16; i++) begin
         hit_cnt = hit_cnt + {{(CNT_W-1){1'b0}}, seen[i]};
      end
   end

   assign all_seen = (hit_cnt == CNT_W'(16));

endmodule

// File: tb/tb_task_v.sv
// Directed self-checking bench for task_v: reset, sweep, repeats, clear, async reset, optional parity.
module tb_task_v;

   logic       clk;
   logic       rst_n;
   logic       a, b, c, d;
   logic       clr;
   logic       f;
   logic       f_q;
   logic [15:0] seen;
   logic [4:0] hit_cnt;
   logic       all_seen;
`ifdef TASKV_PARITY_EN
   logic       par_q;
`endif

   int total;
   int bad;

   // Hand-derived from f = (a&b) | (c&d), index 0 first.
   logic exp_f [16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,
                        1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

   task_v dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .a        (a),
      .b        (b),
      .c        (c),
      .d        (d),
      .clr      (clr),
      .f        (f),
`ifdef TASKV_PARITY_EN
      .par_q    (par_q),
`endif
      .f_q      (f_q),
      .seen     (seen),
      .hit_cnt  (hit_cnt),
      .all_seen (all_seen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_idx(input int i);
      a = i[3];
      b = i[2];
      c = i[1];
      d = i[0];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      clr   = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      set_idx(15);
      rst_n = 1'b0;
      clr   = 1'b0;
      #1;
      total++;
      if (f !== 1'b1) begin bad++; $display("FAIL reset_f_follows got=%b want=1", f); end
      step();
      total++;
      if (f_q !== 1'b0) begin bad++; $display("FAIL reset_f_q got=%b want=0", f_q); end
      total++;
      if (seen !== 16'h0000) begin bad++; $display("FAIL reset_seen got=%h want=0000", seen); end
      total++;
      if (hit_cnt !== 5'd0) begin bad++; $display("FAIL reset_hit_cnt got=%0d want=0", hit_cnt); end
      total++;
      if (all_seen !== 1'b0) begin bad++; $display("FAIL reset_all_seen got=%b want=0", all_seen); end
      rst_n = 1'b1;
      set_idx(0);
      #1;
      total++;
      if (f !== 1'b0) begin bad++; $display("FAIL idx0_f got=%b want=0", f); end
      step();
      total++;
      if (f_q !== 1'b0) begin bad++; $display("FAIL idx0_f_q got=%b want=0", f_q); end
      total++;
      if (seen !== 16'h0001) begin bad++; $display("FAIL idx0_seen got=%h want=0001", seen); end
      total++;
      if (hit_cnt !== 5'd1) begin bad++; $display("FAIL idx0_hit_cnt got=%0d want=1", hit_cnt); end
   endtask

   task automatic test_sweep();
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         set_idx(i);
         #1;
         total++;
         if (f !== exp_f[i]) begin bad++; $display("FAIL sweep_f idx=%0d got=%b want=%b", i, f, exp_f[i]); end
         step();
         total++;
         if (f_q !== exp_f[i]) begin bad++; $display("FAIL sweep_f_q idx=%0d got=%b want=%b", i, f_q, exp_f[i]); end
         total++;
         if (hit_cnt !== 5'(i + 1)) begin bad++; $display("FAIL sweep_hit_cnt idx=%0d got=%0d want=%0d", i, hit_cnt, i + 1); end
         if (i < 15) begin
            total++;
            if (all_seen !== 1'b0) begin bad++; $display("FAIL sweep_all_seen_early idx=%0d got=%b want=0", i, all_seen); end
         end
      end
      total++;
      if (seen !== 16'hFFFF) begin bad++; $display("FAIL sweep_seen got=%h want=ffff", seen); end
      total++;
      if (hit_cnt !== 5'd16) begin bad++; $display("FAIL sweep_hit_final got=%0d want=16", hit_cnt); end
      total++;
      if (all_seen !== 1'b1) begin bad++; $display("FAIL sweep_all_seen got=%b want=1", all_seen); end
   endtask

   task automatic test_repeat();
      apply_reset();
      set_idx(15);
      for (int i = 0; i < 5; i++) step();
      total++;
      if (seen !== 16'h8000) begin bad++; $display("FAIL repeat_seen got=%h want=8000", seen); end
      total++;
      if (hit_cnt !== 5'd1) begin bad++; $display("FAIL repeat_hit_cnt got=%0d want=1", hit_cnt); end
      total++;
      if (f !== 1'b1) begin bad++; $display("FAIL repeat_f got=%b want=1", f); end
      total++;
      if (f_q !== 1'b1) begin bad++; $display("FAIL repeat_f_q got=%b want=1", f_q); end
   endtask

   task automatic test_clr();
      apply_reset();
      for (int i = 0; i < 16; i++) begin
         set_idx(i);
         step();
      end
      total++;
      if (all_seen !== 1'b1) begin bad++; $display("FAIL clr_pre_all_seen got=%b want=1", all_seen); end
      set_idx(5);
      clr = 1'b1;
      step();
      clr = 1'b0;
      total++;
      if (seen !== 16'h0000) begin bad++; $display("FAIL clr_seen got=%h want=0000", seen); end
      total++;
      if (hit_cnt !== 5'd0) begin bad++; $display("FAIL clr_hit_cnt got=%0d want=0", hit_cnt); end
      total++;
      if (all_seen !== 1'b0) begin bad++; $display("FAIL clr_all_seen got=%b want=0", all_seen); end
      total++;
      if (f_q !== 1'b0) begin bad++; $display("FAIL clr_f_q got=%b want=0", f_q); end
      step();
      total++;
      if (seen !== 16'h0020) begin bad++; $display("FAIL clr_next_seen got=%h want=0020", seen); end
      total++;
      if (hit_cnt !== 5'd1) begin bad++; $display("FAIL clr_next_hit got=%0d want=1", hit_cnt); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      for (int i = 0; i < 8; i++) begin
         set_idx(i);
         step();
      end
      total++;
      if (seen !== 16'h00FF) begin bad++; $display("FAIL async_pre_seen got=%h want=00ff", seen); end
      total++;
      if (f_q !== 1'b1) begin bad++; $display("FAIL async_pre_f_q got=%b want=1", f_q); end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (seen !== 16'h0000) begin bad++; $display("FAIL async_seen got=%h want=0000", seen); end
      total++;
      if (f_q !== 1'b0) begin bad++; $display("FAIL async_f_q got=%b want=0", f_q); end
      total++;
      if (hit_cnt !== 5'd0) begin bad++; $display("FAIL async_hit_cnt got=%0d want=0", hit_cnt); end
      step();
      rst_n = 1'b1;
      set_idx(3);
      step();
      total++;
      if (seen !== 16'h0008) begin bad++; $display("FAIL async_resume_seen got=%h want=0008", seen); end
   endtask

`ifdef TASKV_PARITY_EN
   task automatic test_parity();
      apply_reset();
      set_idx(7);
      step();
      total++;
      if (par_q !== 1'b1) begin bad++; $display("FAIL parity_idx7 got=%b want=1", par_q); end
      set_idx(12);
      step();
      total++;
      if (par_q !== 1'b0) begin bad++; $display("FAIL parity_idx12 got=%b want=0", par_q); end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      clr   = 1'b0;
      set_idx(0);
      test_reset();
      test_sweep();
      test_repeat();
      test_clr();
      test_async_reset();
`ifdef TASKV_PARITY_EN
      test_parity();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
